// File: rtl/sba_arb_pkg.sv
// Shared types and defaults for the two-requester SBA arbiter.
// Contents: requester-id type and the default in-flight limit.
// Imported by sba_arbiter; the id type is also the element type of its id FIFO.
package sba_arb_pkg;

    // Requester identifier: 0 = h0, 1 = h1.
    typedef logic id_t;

    // Default number of granted-but-unanswered transactions.
    localparam int unsigned MaxOutstandingDefault = 4;

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO, registered output unless FALL_THROUGH is set.
// Latency: one cycle from push to visible head (zero with FALL_THROUGH).
// Backpressure: push ignored when full, pop ignored when empty; full_o/empty_o inform the user.
// Ports: clk_i/rst_ni (async active-low), flush_i, full_o, empty_o, usage_o, data_i/push_i, data_o/pop_i.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,        // power of two
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    localparam logic [ADDR_DEPTH:0] FullCnt = (ADDR_DEPTH+1)'(DEPTH);

    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    dtype                  mem_q [DEPTH];
    dtype                  mem_d [DEPTH];

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
    // At full the low bits wrap to zero; users combine usage_o with full_o.
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        data_o   = mem_q[rd_ptr_q];

        if (push_i && !full_o) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            cnt_d           = cnt_q + 1'b1;
        end

        if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d    = (push_i && !full_o) ? cnt_q : cnt_q - 1'b1;
        end

        // Fall-through on empty: the pushed word leaves directly and is not stored.
        if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
            data_o = data_i;
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q;
                wr_ptr_d = wr_ptr_q;
                cnt_d    = cnt_q;
            end
        end

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= dtype'(0);
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/sba_arbiter.sv
// Two-requester round-robin arbiter onto one req/gnt SBA target port, with in-order response routing.
// Latency: request/grant combinational pass-through; responses routed combinationally via an id FIFO.
// Backpressure: target gnt passed to the selected requester; all grants held off at MaxOutstanding in flight.
// Ports: clk_i, rst_i (async active-high), h0_*/h1_* requester channels, t_* target channel,
//        outstanding_o (in-flight count), unexp_rsp_o (response with nothing in flight).
module sba_arbiter
    import sba_arb_pkg::*;
#(
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned MaxOutstanding = MaxOutstandingDefault
) (
    input  logic                             clk_i,
    input  logic                             rst_i,

    input  logic                             h0_req_i,
    input  logic                             h0_we_i,
    input  logic [AddrWidth-1:0]             h0_addr_i,
    input  logic [DataWidth/8-1:0]           h0_be_i,
    input  logic [DataWidth-1:0]             h0_wdata_i,
    output logic                             h0_gnt_o,
    output logic                             h0_r_valid_o,
    output logic [DataWidth-1:0]             h0_r_rdata_o,

    input  logic                             h1_req_i,
    input  logic                             h1_we_i,
    input  logic [AddrWidth-1:0]             h1_addr_i,
    input  logic [DataWidth/8-1:0]           h1_be_i,
    input  logic [DataWidth-1:0]             h1_wdata_i,
    output logic                             h1_gnt_o,
    output logic                             h1_r_valid_o,
    output logic [DataWidth-1:0]             h1_r_rdata_o,

    output logic                             t_req_o,
    output logic                             t_we_o,
    output logic [AddrWidth-1:0]             t_addr_o,
    output logic [DataWidth/8-1:0]           t_be_o,
    output logic [DataWidth-1:0]             t_wdata_o,
    input  logic                             t_gnt_i,
    input  logic                             t_r_valid_i,
    input  logic [DataWidth-1:0]             t_r_rdata_i,

    output logic [$clog2(MaxOutstanding):0]  outstanding_o,
    output logic                             unexp_rsp_o
);

    localparam int unsigned PtrWidth = $clog2(MaxOutstanding);

    id_t                rr_q, rr_d;     // id of the requester that wins a tie
    id_t                sel_id;
    id_t                head_id;
    logic               fifo_full;
    logic               fifo_empty;
    logic [PtrWidth-1:0] fifo_usage;
    logic               accept;
    logic               rsp_pop;

    always_comb begin
        if (h0_req_i && h1_req_i) begin
            sel_id = rr_q;
        end else if (h1_req_i) begin
            sel_id = 1'b1;
        end else begin
            sel_id = 1'b0;
        end

        t_req_o   = !fifo_full && (sel_id ? h1_req_i : h0_req_i);
        t_we_o    = sel_id ? h1_we_i    : h0_we_i;
        t_addr_o  = sel_id ? h1_addr_i  : h0_addr_i;
        t_be_o    = sel_id ? h1_be_i    : h0_be_i;
        t_wdata_o = sel_id ? h1_wdata_i : h0_wdata_i;

        h0_gnt_o  = t_gnt_i && !sel_id && !fifo_full;
        h1_gnt_o  = t_gnt_i &&  sel_id && !fifo_full;

        accept    = t_req_o && t_gnt_i;
        // After a grant the other requester wins the next tie.
        rr_d      = accept ? ~sel_id : rr_q;

        rsp_pop      = t_r_valid_i && !fifo_empty;
        h0_r_valid_o = rsp_pop && (head_id == 1'b0);
        h1_r_valid_o = rsp_pop && (head_id == 1'b1);
        h0_r_rdata_o = t_r_rdata_i;
        h1_r_rdata_o = t_r_rdata_i;

        // Gate with reset so a response seen while reset is held is not flagged.
        unexp_rsp_o  = t_r_valid_i && fifo_empty && !rst_i;

        // usage wraps to zero at full, so full supplies the top bit.
        outstanding_o = {fifo_full, fifo_usage};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (1),
        .DEPTH        (MaxOutstanding),
        .dtype        (id_t)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (~rst_i),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage),
        .data_i  (sel_id),
        .push_i  (accept),
        .data_o  (head_id),
        .pop_i   (rsp_pop)
    );

endmodule

// File: tb/tb_sba_arbiter.sv
module tb_sba_arbiter;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        h0_req, h0_we, h1_req, h1_we;
    logic [63:0] h0_addr, h0_wdata, h1_addr, h1_wdata;
    logic [7:0]  h0_be, h1_be;
    logic        h0_gnt, h0_rv, h1_gnt, h1_rv;
    logic [63:0] h0_rd, h1_rd;
    logic        t_req, t_we;
    logic [63:0] t_addr, t_wdata;
    logic [7:0]  t_be;
    logic        t_gnt, t_rv;
    logic [63:0] t_rdata;
    logic [2:0]  outstanding;
    logic        unexp;

    sba_arbiter #(.AddrWidth(64), .DataWidth(64), .MaxOutstanding(MAXO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .h0_req_i(h0_req), .h0_we_i(h0_we), .h0_addr_i(h0_addr), .h0_be_i(h0_be), .h0_wdata_i(h0_wdata),
        .h0_gnt_o(h0_gnt), .h0_r_valid_o(h0_rv), .h0_r_rdata_o(h0_rd),
        .h1_req_i(h1_req), .h1_we_i(h1_we), .h1_addr_i(h1_addr), .h1_be_i(h1_be), .h1_wdata_i(h1_wdata),
        .h1_gnt_o(h1_gnt), .h1_r_valid_o(h1_rv), .h1_r_rdata_o(h1_rd),
        .t_req_o(t_req), .t_we_o(t_we), .t_addr_o(t_addr), .t_be_o(t_be), .t_wdata_o(t_wdata),
        .t_gnt_i(t_gnt), .t_r_valid_i(t_rv), .t_r_rdata_i(t_rdata),
        .outstanding_o(outstanding), .unexp_rsp_o(unexp)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: ids of accepted transactions awaiting a response, and the tie winner.
    int q[$];
    int prio = 0;

    // Observations of the last modelled cycle, for scenario-level checks.
    int          last_sel;
    bit          last_acc, last_rv0, last_rv1, last_unexp;
    logic [63:0] last_rd0, last_rd1;
    int          order [6];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        h0_req = 0; h1_req = 0; t_gnt = 0; t_rv = 0;
    endtask

    // One clock cycle: inputs already driven; compare at negedge, advance model, step past posedge.
    task automatic cyc();
        int sel;
        bit full;
        @(negedge clk);
        full = (q.size() == MAXO);
        sel  = -1;
        if (!full) begin
            if (h0_req && h1_req) sel = prio;
            else if (h0_req)      sel = 0;
            else if (h1_req)      sel = 1;
        end
        chk("outstanding", 64'(outstanding), 64'(q.size()));
        chk("t_req", 64'(t_req), 64'(sel >= 0));
        if (sel >= 0) begin
            chk("t_we",    64'(t_we),    64'((sel == 1) ? h1_we : h0_we));
            chk("t_addr",  t_addr,       (sel == 1) ? h1_addr : h0_addr);
            chk("t_be",    64'(t_be),    64'((sel == 1) ? h1_be : h0_be));
            chk("t_wdata", t_wdata,      (sel == 1) ? h1_wdata : h0_wdata);
        end
        if (h0_req || h1_req) begin
            chk("h0_gnt", 64'(h0_gnt), 64'(t_gnt && sel == 0));
            chk("h1_gnt", 64'(h1_gnt), 64'(t_gnt && sel == 1));
        end
        chk("h0_r_valid", 64'(h0_rv), 64'(t_rv && q.size() > 0 && q[0] == 0));
        chk("h1_r_valid", 64'(h1_rv), 64'(t_rv && q.size() > 0 && q[0] == 1));
        chk("unexp_rsp",  64'(unexp), 64'(t_rv && q.size() == 0));
        chk("h0_rdata", h0_rd, t_rdata);
        chk("h1_rdata", h1_rd, t_rdata);

        last_sel   = sel;
        last_acc   = (sel >= 0) && t_gnt;
        last_rv0   = h0_rv;
        last_rv1   = h1_rv;
        last_rd0   = h0_rd;
        last_rd1   = h1_rd;
        last_unexp = unexp;

        if (t_rv && q.size() > 0) void'(q.pop_front());
        if (last_acc) begin
            q.push_back(sel);
            prio = 1 - sel;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1;
        t_rv  = 1;
        #1;
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_unexp", 64'(unexp), 64'd0);
        q.delete();
        prio = 0;
        @(posedge clk);
        #1;
        rst_i = 0;
        t_rv  = 0;
    endtask

    initial begin
        rst_i = 1;
        idle();
        h0_we = 0; h1_we = 0; h0_addr = '0; h1_addr = '0;
        h0_be = '0; h1_be = '0; h0_wdata = '0; h1_wdata = '0; t_rdata = '0;
        @(posedge clk);
        #1;
        do_reset();

        // h0 alone reads 0x8000_0000; answer two cycles later with 0xDEAD_BEEF.
        h0_req = 1; h0_we = 0; h0_addr = 64'h8000_0000; h0_be = 8'hFF; t_gnt = 1;
        cyc();
        chk("s1_gnt_h0", 64'(last_acc && last_sel == 0), 64'd1);
        idle();
        cyc();
        t_rv = 1; t_rdata = 64'hDEAD_BEEF;
        cyc();
        chk("s1_rv_h0",  64'(last_rv0), 64'd1);
        chk("s1_rdata",  last_rd0, 64'hDEAD_BEEF);
        chk("s1_rv_h1",  64'(last_rv1), 64'd0);
        idle();

        // Continuous contention from both requesters: strict alternation starting at h0.
        do_reset();
        h0_req = 1; h1_req = 1; h0_addr = 64'h100; h1_addr = 64'h200; t_gnt = 1; t_rv = 1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            order[i] = last_sel;
        end
        for (int i = 0; i < 6; i++) chk("s2_order", 64'(order[i]), 64'(i % 2));
        idle();

        // Fill to MaxOutstanding, then the fifth request waits for a response.
        do_reset();
        h0_req = 1; t_gnt = 1;
        for (int i = 0; i < MAXO; i++) cyc();
        chk("s3_full", 64'(outstanding), 64'(MAXO));
        cyc();
        chk("s3_blocked", 64'(last_acc), 64'd0);
        t_rv = 1; t_rdata = 64'h55;
        cyc();
        chk("s3_no_bypass", 64'(last_acc), 64'd0);
        t_rv = 0;
        cyc();
        chk("s3_granted", 64'(last_acc), 64'd1);
        h0_req = 0; t_gnt = 0; t_rv = 1;
        for (int i = 0; i < MAXO; i++) cyc();
        idle();

        // Interleaved h1,h0,h1 accepts; responses route back in order.
        t_gnt = 1;
        h1_req = 1; cyc(); h1_req = 0;
        h0_req = 1; cyc(); h0_req = 0;
        h1_req = 1; cyc(); h1_req = 0;
        t_gnt = 0; t_rv = 1;
        t_rdata = 64'h1; cyc();
        chk("s4_rsp1_h1", 64'({last_rv1, last_rv0}), 64'b10);
        chk("s4_rsp1_data", last_rd1, 64'h1);
        t_rdata = 64'h2; cyc();
        chk("s4_rsp2_h0", 64'({last_rv1, last_rv0}), 64'b01);
        chk("s4_rsp2_data", last_rd0, 64'h2);
        t_rdata = 64'h3; cyc();
        chk("s4_rsp3_h1", 64'({last_rv1, last_rv0}), 64'b10);
        chk("s4_rsp3_data", last_rd1, 64'h3);

        // Unexpected response with nothing in flight: one-cycle pulse only.
        cyc();
        chk("s5_unexp", 64'(last_unexp), 64'd1);
        chk("s5_no_rv", 64'({last_rv1, last_rv0}), 64'b00);
        t_rv = 0;
        cyc();
        chk("s5_unexp_gone", 64'(last_unexp), 64'd0);

        // Reset with two in flight, last grant to h0 (so without reset h1 would win).
        t_gnt = 1;
        h1_req = 1; cyc(); h1_req = 0;
        h0_req = 1; cyc(); h0_req = 0;
        chk("s6_pre_outstanding", 64'(outstanding), 64'd2);
        t_gnt = 0;
        do_reset();
        t_rv = 1;
        cyc();
        chk("s6_post_rst_unexp", 64'(last_unexp), 64'd1);
        t_rv = 0; h0_req = 1; h1_req = 1; t_gnt = 1;
        cyc();
        chk("s6_h0_wins", 64'(last_sel), 64'd0);
        idle();
        t_rv = 1;
        cyc();
        idle();

        // Randomised traffic; requesters hold their request and payload until accepted.
        for (int n = 0; n < 600; n++) begin
            if (!h0_req && $urandom_range(0, 2) != 0) begin
                h0_req = 1; h0_we = 1'($urandom); h0_addr = {$urandom, $urandom};
                h0_be = 8'($urandom); h0_wdata = {$urandom, $urandom};
            end
            if (!h1_req && $urandom_range(0, 2) != 0) begin
                h1_req = 1; h1_we = 1'($urandom); h1_addr = {$urandom, $urandom};
                h1_be = 8'($urandom); h1_wdata = {$urandom, $urandom};
            end
            t_gnt   = ($urandom_range(0, 3) != 0);
            t_rv    = ($urandom_range(0, 2) == 0);
            t_rdata = {$urandom, $urandom};
            cyc();
            if (last_acc && last_sel == 0) h0_req = 0;
            if (last_acc && last_sel == 1) h1_req = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
